dmem_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port data memory (4 x 8-bit, combinational read, write on clk when MemWrite=1).
- Requester 0 is the CPU pipeline MEM stage; requester 1 is the debug/loader port.
- The block serialises accesses, drives MemWrite/MemRead/Address/WriteData, and returns a registered response to the requester that was granted.
- Arbitration is round-robin by default, or fixed priority to requester 0.

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_rr_pick2.sv | 27 ++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus the single-port memory bus around the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DIR_WIDTH = 8
) ();
    logic                      r0_req;
    logic                      r0_we;
    logic [DATA_DIR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0]     r0_wdata;
    logic                      r0_gnt;
    logic                      r0_rsp;
    logic [DATA_WIDTH-1:0]     r0_rdata;

    logic                      r1_req;
    logic                      r1_we;
    logic [DATA_DIR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0]     r1_wdata;
    logic                      r1_gnt;
    logic                      r1_rsp;
    logic [DATA_WIDTH-1:0]     r1_rdata;

    logic                      MemWrite;
    logic                      MemRead;
    logic [DATA_DIR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0]     WriteData;
    logic [DATA_WIDTH-1:0]     ReadData;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rsp, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rsp, r1_rdata,
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rsp, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rsp, r1_rdata,
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin on last winner, or fixed
// priority to requester 0 when fixed_prio is set.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic [1:0] gnt,
    output logic       win
);

    // Resolve the winner id, then one-hot encode it when anyone is asking.
    always_comb begin
        win = REQ_CPU;
        gnt = 2'b00;
        case (req)
            2'b01:   win = REQ_CPU;
            2'b10:   win = REQ_DBG;
            2'b11:   win = fixed_prio ? REQ_CPU : ~last;
            default: win = REQ_CPU;
        endcase
        if (req != 2'b00)
            gnt = win ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the single-port data memory: grant in IDLE,
// one ACCESS cycle on the memory, registered response the cycle after.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DIR_WIDTH = 8,
    parameter int FIXED_PRIO     = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_t                    state_q, state_d;
    logic                      last_q, last_d;
    logic                      we_q, we_d;
    logic [DATA_DIR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      id_q, id_d;
    logic [1:0]                rsp_q, rsp_d;
    logic [DATA_WIDTH-1:0]     rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]     rdata1_q, rdata1_d;

    logic [1:0] pick_gnt;
    logic       pick_win;
    logic [1:0] gnt;
    logic       in_access;

    rr_pick2 u_pick (
        .req        ({bus.r1_req, bus.r0_req}),
        .last       (last_q),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (pick_gnt),
        .win        (pick_win)
    );

    // Grants only from IDLE and never while reset is held.
    assign gnt = (state_q == IDLE && !rst) ? pick_gnt : 2'b00;

    // Memory strobes come from state so an access aborted by reset never writes.
    assign in_access = (state_q == ACCESS) && !rst;

    // Next state, command capture on grant, response/read-data capture on access.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        id_d     = id_q;
        rsp_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    state_d = ACCESS;
                    last_d  = pick_win;
                    id_d    = pick_win;
                    if (pick_win == REQ_CPU) begin
                        we_d    = bus.r0_we;
                        addr_d  = bus.r0_addr;
                        wdata_d = bus.r0_wdata;
                    end else begin
                        we_d    = bus.r1_we;
                        addr_d  = bus.r1_addr;
                        wdata_d = bus.r1_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d      = IDLE;
                rsp_d[id_q]  = 1'b1;
                if (!we_q) begin
                    if (id_q == REQ_CPU) rdata0_d = bus.ReadData;
                    else                 rdata1_d = bus.ReadData;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= REQ_DBG;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            id_q     <= REQ_CPU;
            rsp_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            id_q     <= id_d;
            rsp_q    <= rsp_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.r0_gnt    = gnt[0];
    assign bus.r1_gnt    = gnt[1];
    assign bus.r0_rsp    = rsp_q[0];
    assign bus.r1_rsp    = rsp_q[1];
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
    assign bus.MemWrite  = in_access && we_q;
    assign bus.MemRead   = in_access && !we_q;
    assign bus.Address   = addr_q;
    assign bus.WriteData = wdata_q;

endmodule
